// File: rtl/ped_crossing_pkg.sv
// Shared types and defaults for the pedestrian crossing block: FSM state codes,
// lamp identities and the lamp-sequence helpers used by the legality checker.
package ped_crossing_pkg;

    localparam int DEF_WALK_CYC = 16;
    localparam int DEF_CLR_CYC  = 8;
    localparam int DEF_PASS_TO  = 64;
    localparam int DEF_CNT_W    = 8;
    localparam int PED_ST_W     = 3;

    typedef enum logic [PED_ST_W-1:0] {
        PED_IDLE  = 3'd0,
        PED_REQ   = 3'd1,
        PED_WALK  = 3'd2,
        PED_CLEAR = 3'd3,
        PED_FAULT = 3'd4
    } ped_st_e;

    typedef enum logic [1:0] {
        LAMP_NONE = 2'd0,
        LAMP_G    = 2'd1,
        LAMP_Y    = 2'd2,
        LAMP_R    = 2'd3
    } lamp_e;

    // Anything other than exactly one lit lamp maps to LAMP_NONE.
    function automatic lamp_e lamp_of(input logic r, input logic g, input logic y);
        case ({r, g, y})
            3'b100:  return LAMP_R;
            3'b010:  return LAMP_G;
            3'b001:  return LAMP_Y;
            default: return LAMP_NONE;
        endcase
    endfunction

    function automatic lamp_e lamp_succ(input lamp_e l);
        case (l)
            LAMP_G:  return LAMP_Y;
            LAMP_Y:  return LAMP_R;
            LAMP_R:  return LAMP_G;
            default: return LAMP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ped_crossing_lamp_checker.sv
// Lamp legality checker: flags any non-one-hot pattern and any lamp change
// outside G->Y->R->G. viol is combinational so the caller registers it once.
module lamp_checker
    import ped_crossing_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic R,
    input  logic G,
    input  logic Y,
    output logic viol
);

    lamp_e cur_s;
    lamp_e last_q;
    lamp_e last_d;

    // Pattern and order check against the last legal lamp seen.
    always_comb begin
        cur_s  = lamp_of(R, G, Y);
        last_d = last_q;
        viol   = 1'b0;
        if (cur_s == LAMP_NONE) begin
            viol = 1'b1;
        end else begin
            last_d = cur_s;
            if ((last_q != LAMP_NONE) && (cur_s != last_q) && (cur_s != lamp_succ(last_q))) begin
                viol = 1'b1;
            end else begin
                viol = 1'b0;
            end
        end
    end

    // Last-lamp register; LAMP_NONE after reset skips the first order check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAMP_NONE;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller: latches requests, drives pass to the light,
// runs WALK then flashing CLEAR while red, and traps lamp faults.
module ped_crossing
    import ped_crossing_pkg::*;
#(
    parameter int WALK_CYC = DEF_WALK_CYC,
    parameter int CLR_CYC  = DEF_CLR_CYC,
    parameter int PASS_TO  = DEF_PASS_TO,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             R,
    input  logic             G,
    input  logic             Y,
    output logic             pass,
    output logic             walk,
    output logic             flash,
    output logic             short_r,
    output logic             err,
    output logic [CNT_W-1:0] served
);

    localparam int MAX_P = (PASS_TO > WALK_CYC) ? ((PASS_TO > CLR_CYC) ? PASS_TO : CLR_CYC)
                                                : ((WALK_CYC > CLR_CYC) ? WALK_CYC : CLR_CYC);
    localparam int TMR_W = $clog2(MAX_P) + 1;

    ped_st_e          st_q, st_d;
    logic [TMR_W-1:0] tmr_q, tmr_d, tmr_term_s;
    logic             btn_q, req_q, req_d;
    logic             pass_q, walk_q, flash_q, flash_d;
    logic             short_q, short_d, err_q, err_d;
    logic [CNT_W-1:0] served_q, served_d;
    logic             viol_s;

    lamp_checker ul_chk (
        .clk  (clk),
        .rst  (rst),
        .R    (R),
        .G    (G),
        .Y    (Y),
        .viol (viol_s)
    );

    // Next state and sticky flags; a lamp violation overrides every phase.
    always_comb begin
        st_d     = st_q;
        short_d  = short_q;
        err_d    = err_q;
        served_d = served_q;
        if (st_q == PED_FAULT) begin
            st_d = PED_FAULT;
        end else if (viol_s) begin
            st_d  = PED_FAULT;
            err_d = 1'b1;
        end else begin
            case (st_q)
                PED_IDLE: begin
                    if (req_q) st_d = PED_REQ;
                    else       st_d = PED_IDLE;
                end
                PED_REQ: begin
                    if (R) begin
                        st_d = PED_WALK;
                    end else if (tmr_q == TMR_W'(PASS_TO - 1)) begin
                        st_d  = PED_FAULT;
                        err_d = 1'b1;
                    end else begin
                        st_d = PED_REQ;
                    end
                end
                PED_WALK: begin
                    // Completion is tested first so a same-cycle R fall is not a short red.
                    if (tmr_q == TMR_W'(WALK_CYC - 1)) begin
                        st_d = PED_CLEAR;
                    end else if (!R) begin
                        st_d    = PED_IDLE;
                        short_d = 1'b1;
                    end else begin
                        st_d = PED_WALK;
                    end
                end
                PED_CLEAR: begin
                    if (tmr_q == TMR_W'(CLR_CYC - 1)) begin
                        st_d     = PED_IDLE;
                        served_d = served_q + CNT_W'(1);
                    end else if (!R) begin
                        st_d    = PED_IDLE;
                        short_d = 1'b1;
                    end else begin
                        st_d = PED_CLEAR;
                    end
                end
                default: begin
                    st_d  = PED_FAULT;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Phase timer, request latch and flash pattern.
    always_comb begin
        case (st_q)
            PED_REQ:   tmr_term_s = TMR_W'(PASS_TO - 1);
            PED_WALK:  tmr_term_s = TMR_W'(WALK_CYC - 1);
            PED_CLEAR: tmr_term_s = TMR_W'(CLR_CYC - 1);
            default:   tmr_term_s = '0;
        endcase
        if (st_d != st_q) begin
            tmr_d = '0;
        end else if (tmr_q == tmr_term_s) begin
            tmr_d = tmr_q;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if ((st_d == PED_WALK) && (st_q != PED_WALK)) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q | (btn & ~btn_q);
        end
        if (st_d == PED_CLEAR) begin
            flash_d = (st_q == PED_CLEAR) ? ~flash_q : 1'b1;
        end else begin
            flash_d = 1'b0;
        end
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= PED_IDLE;
            tmr_q    <= '0;
            btn_q    <= 1'b0;
            req_q    <= 1'b0;
            pass_q   <= 1'b0;
            walk_q   <= 1'b0;
            flash_q  <= 1'b0;
            short_q  <= 1'b0;
            err_q    <= 1'b0;
            served_q <= '0;
        end else begin
            st_q     <= st_d;
            tmr_q    <= tmr_d;
            btn_q    <= btn;
            req_q    <= req_d;
            pass_q   <= (st_d == PED_REQ);
            walk_q   <= (st_d == PED_WALK);
            flash_q  <= flash_d;
            short_q  <= short_d;
            err_q    <= err_d;
            served_q <= served_d;
        end
    end

    assign pass    = pass_q;
    assign walk    = walk_q;
    assign flash   = flash_q;
    assign short_r = short_q;
    assign err     = err_q;
    assign served  = served_q;

endmodule

// File: tb/tb_ped_crossing.sv
// Scoreboard bench for ped_crossing: a phase/countdown reference model pushes
// the expected outputs for every clock edge; a monitor pops and compares them.
module tb_ped_crossing;

    localparam int WALK_N = 16;
    localparam int CLR_N  = 8;
    localparam int TO_N   = 64;

    // Lamp codes: index order G,Y,R makes the legal successor (i+1)%3.
    localparam int L_G = 0, L_Y = 1, L_R = 2, L_RG = 3, L_OFF = 4;
    localparam int M_IDLE = 0, M_REQ = 1, M_WALK = 2, M_CLEAR = 3, M_FAULT = 4;

    typedef struct {
        bit pass;
        bit walk;
        bit flash;
        bit short_r;
        bit err;
        int served;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, btn, R, G, Y;
    logic       pass, walk, flash, short_r, err;
    logic [7:0] served;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    int m_phase, m_left, m_last, m_served;
    bit m_req, m_btn_prev, m_short, m_err, m_flash;

    always #5 clk = ~clk;

    ped_crossing dut (
        .clk(clk), .rst(rst), .btn(btn), .R(R), .G(G), .Y(Y),
        .pass(pass), .walk(walk), .flash(flash), .short_r(short_r),
        .err(err), .served(served)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = M_IDLE; m_left = 0; m_last = -1; m_served = 0;
        m_req = 1'b0; m_btn_prev = 1'b0; m_short = 1'b0; m_err = 1'b0; m_flash = 1'b0;
    endfunction

    function automatic void model_step(input bit b, input int lamp);
        bit r, rise, fault_now, to_walk, was_clear;
        int lit;
        r         = (lamp == L_R) || (lamp == L_RG);
        lit       = (lamp < 3) ? 1 : ((lamp == L_RG) ? 2 : 0);
        fault_now = (lit != 1);
        if (lit == 1) begin
            if (m_last >= 0 && lamp != m_last && lamp != (m_last + 1) % 3) fault_now = 1'b1;
            m_last = lamp;
        end
        rise       = b && !m_btn_prev;
        m_btn_prev = b;
        to_walk    = 1'b0;
        was_clear  = (m_phase == M_CLEAR);
        if (m_phase == M_FAULT) begin
            m_phase = M_FAULT;
        end else if (fault_now) begin
            m_phase = M_FAULT; m_err = 1'b1;
        end else begin
            case (m_phase)
                M_IDLE: if (m_req) begin m_phase = M_REQ; m_left = TO_N; end
                M_REQ: begin
                    if (r) begin m_phase = M_WALK; m_left = WALK_N; to_walk = 1'b1; end
                    else if (m_left == 1) begin m_phase = M_FAULT; m_err = 1'b1; end
                    else m_left--;
                end
                M_WALK: begin
                    if (m_left == 1) begin m_phase = M_CLEAR; m_left = CLR_N; end
                    else if (!r) begin m_phase = M_IDLE; m_short = 1'b1; end
                    else m_left--;
                end
                M_CLEAR: begin
                    if (m_left == 1) begin m_phase = M_IDLE; m_served = (m_served + 1) % 256; end
                    else if (!r) begin m_phase = M_IDLE; m_short = 1'b1; end
                    else m_left--;
                end
                default: m_phase = M_FAULT;
            endcase
        end
        m_req   = to_walk ? 1'b0 : (m_req | rise);
        m_flash = (m_phase == M_CLEAR) ? (was_clear ? !m_flash : 1'b1) : 1'b0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pass    = (m_phase == M_REQ);
        e.walk    = (m_phase == M_WALK);
        e.flash   = m_flash;
        e.short_r = m_short;
        e.err     = m_err;
        e.served  = m_served;
        exp_q.push_back(e);
    endfunction

    task automatic set_lamp(input int lamp);
        R = (lamp == L_R) || (lamp == L_RG);
        G = (lamp == L_G) || (lamp == L_RG);
        Y = (lamp == L_Y);
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic step(input bit b, input int lamp, input bit r_in);
        @(negedge clk);
        rst = r_in;
        btn = b;
        set_lamp(lamp);
        if (r_in) model_reset();
        else      model_step(b, lamp);
        push_exp();
    endtask

    task automatic async_reset();
        @(negedge clk);
        btn = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_pass", pass, 0);
        chk("async_walk", walk, 0);
        chk("async_flash", flash, 0);
        chk("async_short", short_r, 0);
        chk("async_err", err, 0);
        chk("async_served", served, 0);
        model_reset();
        push_exp();
    endtask

    task automatic do_reset();
        step(1'b0, L_G, 1'b1);
        step(1'b0, L_G, 1'b1);
    endtask

    task automatic traffic(input int n);
        int idx, hold;
        idx = L_G; hold = 3;
        for (int i = 0; i < n; i++) begin
            if (hold == 0) begin
                idx  = (idx + 1) % 3;
                hold = (idx == L_R) ? int'($urandom_range(2, 40))
                     : ((idx == L_G) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 4)));
            end else begin
                hold--;
            end
            step($urandom_range(0, 5) == 0, idx, 1'b0);
        end
    endtask

    // Monitor: compare every DUT output one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("pass", pass, mon_e.pass);
            chk("walk", walk, mon_e.walk);
            chk("flash", flash, mon_e.flash);
            chk("short_r", short_r, mon_e.short_r);
            chk("err", err, mon_e.err);
            chk("served", served, mon_e.served);
        end
    end

    initial begin
        rst = 1'b1; btn = 1'b0;
        set_lamp(L_G);
        do_reset();

        // Normal crossing: press, G -> Y -> R ten cycles later.
        step(1'b1, L_G, 1'b0);
        repeat (4)  step(1'b0, L_G, 1'b0);
        repeat (5)  step(1'b0, L_Y, 1'b0);
        repeat (30) step(1'b0, L_R, 1'b0);
        repeat (3)  step(1'b0, L_G, 1'b0);

        // Red cut short during WALK, then a normal crossing.
        step(1'b1, L_G, 1'b0);
        repeat (2)  step(1'b0, L_Y, 1'b0);
        repeat (6)  step(1'b0, L_R, 1'b0);
        repeat (3)  step(1'b0, L_G, 1'b0);
        step(1'b1, L_G, 1'b0);
        repeat (2)  step(1'b0, L_Y, 1'b0);
        repeat (30) step(1'b0, L_R, 1'b0);
        repeat (2)  step(1'b0, L_G, 1'b0);

        // Press during WALK queues a second crossing.
        step(1'b1, L_G, 1'b0);
        repeat (2)  step(1'b0, L_Y, 1'b0);
        repeat (5)  step(1'b0, L_R, 1'b0);
        step(1'b1, L_R, 1'b0);
        repeat (60) step(1'b0, L_R, 1'b0);
        repeat (2)  step(1'b0, L_G, 1'b0);

        // Red never arrives: pass timeout, then FAULT ignores everything.
        step(1'b1, L_G, 1'b0);
        repeat (70) step(1'b0, L_G, 1'b0);
        repeat (20) step($urandom_range(0, 1) == 1, $urandom_range(0, 4), 1'b0);
        do_reset();

        // Two lamps lit in IDLE, then a G -> R skip.
        repeat (3) step(1'b0, L_G, 1'b0);
        step(1'b0, L_RG, 1'b0);
        repeat (3) step(1'b0, L_G, 1'b0);
        do_reset();
        repeat (3) step(1'b0, L_G, 1'b0);
        step(1'b0, L_R, 1'b0);
        repeat (2) step(1'b0, L_G, 1'b0);
        do_reset();

        // Asynchronous reset in the middle of WALK.
        step(1'b1, L_G, 1'b0);
        step(1'b0, L_Y, 1'b0);
        repeat (10) step(1'b0, L_R, 1'b0);
        async_reset();
        step(1'b0, L_R, 1'b1);
        repeat (3) step(1'b0, L_R, 1'b0);

        // 256 back-to-back crossings under a steady red: served wraps to 0.
        do_reset();
        repeat (256) begin
            step(1'b1, L_R, 1'b0);
            repeat (29) step(1'b0, L_R, 1'b0);
        end
        @(negedge clk);
        chk("served_wrap", served, 0);

        // Random legal traffic, then a dark-lamp fault.
        do_reset();
        traffic(3000);
        step(1'b0, L_OFF, 1'b0);
        repeat (3) step(1'b0, L_G, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
